// File: rtl/wishbone_host_master.sv
// wishbone_host_master
//   Host-command to Wishbone bus master. Turns PING / burst WRITE / burst READ
//   command beats into Wishbone cycles. It returns one response beat per command,
//   or one beat per read word. A rising edge on the interconnect interrupt line
//   triggers a read of INT_ADDR, and the word read is forwarded to the host
//   unsolicited.
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready         host command/data beat handshake
//   in_command/address/data_count/data  command fields (first beat), write data
//   out_valid/out_ready       response beat handshake
//   out_status/address/data/last        response fields
//   wbm_*_o / wbm_*_i         Wishbone master signals, wbm_int_i level interrupt
module wishbone_host_master #(
   parameter logic [31:0] TIMEOUT  = 32'd1000,
   parameter logic [31:0] INT_ADDR = 32'hFF00_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [1:0]  in_command,
   input  logic [31:0] in_address,
   input  logic [15:0] in_data_count,
   input  logic [31:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  out_status,
   output logic [31:0] out_address,
   output logic [31:0] out_data,
   output logic        out_last,
   output logic        wbm_we_o,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic [3:0]  wbm_sel_o,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   input  logic        wbm_ack_i,
   input  logic [31:0] wbm_dat_i,
   input  logic        wbm_int_i
);

   localparam logic [7:0] ST_OK   = 8'h00;
   localparam logic [7:0] ST_TMO  = 8'h01;
   localparam logic [7:0] ST_BAD  = 8'h02;
   localparam logic [7:0] ST_INT  = 8'h80;

   typedef enum logic [2:0] {
      S_IDLE, S_WR_STB, S_WR_DATA, S_RD_STB, S_RD_OUT, S_INT_RD, S_RESP
   } state_t;

   state_t      r_state, w_next;
   logic [31:0] r_addr;
   logic [31:0] r_resp_addr;
   logic [31:0] r_resp_data;
   logic [7:0]  r_status;
   logic [15:0] r_count;
   logic [15:0] r_done;
   logic [31:0] r_wdata;
   logic [31:0] r_rdata;
   logic [31:0] r_tmo;
   logic        r_int_d;
   logic        r_int_pend;

   logic        w_cyc;
   logic        w_stb;
   logic        w_last;
   logic        w_expire;
   logic [31:0] w_addr_inc;

   assign w_cyc = (r_state == S_WR_STB) || (r_state == S_WR_DATA) ||
                  (r_state == S_RD_STB) || (r_state == S_RD_OUT)  ||
                  (r_state == S_INT_RD);
   assign w_stb = (r_state == S_WR_STB) || (r_state == S_RD_STB) ||
                  (r_state == S_INT_RD);
   assign w_last     = ({1'b0, r_done} + 17'd1) == {1'b0, r_count};
   // Expiry is only acted on when no ack is present, so a same-cycle ack wins.
   assign w_expire   = (r_tmo == (TIMEOUT - 32'd1));
   // Slave select byte is never touched by burst address stepping.
   assign w_addr_inc = {r_addr[31:24], r_addr[23:0] + 24'd1};

   assign wbm_cyc_o = w_cyc;
   assign wbm_stb_o = w_stb;
   assign wbm_we_o  = (r_state == S_WR_STB);
   assign wbm_sel_o = w_cyc ? 4'hF : '0;
   assign wbm_adr_o = w_cyc ? r_addr : '0;
   assign wbm_dat_o = (r_state == S_WR_STB) ? r_wdata : '0;

   assign out_valid   = (r_state == S_RD_OUT) || (r_state == S_RESP);
   assign out_status  = (r_state == S_RESP) ? r_status : '0;
   assign out_address = (r_state == S_RD_OUT) ? r_addr :
                        (r_state == S_RESP)   ? r_resp_addr : '0;
   assign out_data    = (r_state == S_RD_OUT) ? r_rdata :
                        (r_state == S_RESP)   ? r_resp_data : '0;
   assign out_last    = (r_state == S_RESP) || ((r_state == S_RD_OUT) && w_last);

   always_comb begin
      w_next   = r_state;
      in_ready = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (r_int_pend) begin
               w_next = S_INT_RD;
            end else begin
               in_ready = 1'b1;
               if (in_valid) begin
                  case (in_command)
                     2'd1:    w_next = S_WR_STB;
                     2'd2:    w_next = S_RD_STB;
                     default: w_next = S_RESP;
                  endcase
               end
            end
         end
         S_WR_STB: begin
            if (wbm_ack_i)     w_next = w_last ? S_RESP : S_WR_DATA;
            else if (w_expire) w_next = S_RESP;
         end
         S_WR_DATA: begin
            in_ready = 1'b1;
            if (in_valid) w_next = S_WR_STB;
         end
         S_RD_STB: begin
            if (wbm_ack_i)     w_next = S_RD_OUT;
            else if (w_expire) w_next = S_RESP;
         end
         S_RD_OUT: begin
            if (out_ready) w_next = w_last ? S_IDLE : S_RD_STB;
         end
         S_INT_RD: begin
            if (wbm_ack_i || w_expire) w_next = S_RESP;
         end
         S_RESP: begin
            if (out_ready) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_addr      <= '0;
         r_resp_addr <= '0;
         r_resp_data <= '0;
         r_status    <= '0;
         r_count     <= '0;
         r_done      <= '0;
         r_wdata     <= '0;
         r_rdata     <= '0;
         r_tmo       <= '0;
         r_int_d     <= 1'b0;
         r_int_pend  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_int_d <= wbm_int_i;

         // A new edge wins over the clear so it is never lost.
         if (wbm_int_i && !r_int_d)
            r_int_pend <= 1'b1;
         else if ((r_state == S_IDLE) && r_int_pend)
            r_int_pend <= 1'b0;

         // Every entry into a strobe state is a state change, which restarts the count.
         if (w_next != r_state) r_tmo <= '0;
         else if (w_stb)        r_tmo <= r_tmo + 32'd1;

         case (r_state)
            S_IDLE: begin
               if (r_int_pend) begin
                  r_addr      <= INT_ADDR;
                  r_resp_addr <= INT_ADDR;
                  r_resp_data <= '0;
                  r_done      <= '0;
               end else if (in_valid) begin
                  r_addr      <= in_address;
                  r_resp_addr <= in_address;
                  r_count     <= (in_data_count == '0) ? 16'd1 : in_data_count;
                  r_wdata     <= in_data;
                  r_done      <= '0;
                  r_resp_data <= '0;
                  r_status    <= (in_command == 2'd3) ? ST_BAD : ST_OK;
               end
            end
            S_WR_STB: begin
               if (wbm_ack_i) begin
                  r_done <= r_done + 16'd1;
                  r_addr <= w_addr_inc;
                  if (w_last) begin
                     r_status    <= ST_OK;
                     r_resp_data <= {16'd0, r_count};
                  end
               end else if (w_expire) begin
                  r_status    <= ST_TMO;
                  r_resp_data <= {16'd0, r_done};
               end
            end
            S_WR_DATA: begin
               if (in_valid) r_wdata <= in_data;
            end
            S_RD_STB: begin
               if (wbm_ack_i) begin
                  r_rdata <= wbm_dat_i;
               end else if (w_expire) begin
                  r_status    <= ST_TMO;
                  r_resp_data <= {16'd0, r_done};
               end
            end
            S_RD_OUT: begin
               if (out_ready) begin
                  r_done <= r_done + 16'd1;
                  r_addr <= w_addr_inc;
               end
            end
            S_INT_RD: begin
               if (wbm_ack_i) begin
                  r_status    <= ST_INT;
                  r_resp_data <= wbm_dat_i;
               end else if (w_expire) begin
                  r_status    <= ST_TMO;
                  r_resp_data <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_wishbone_host_master.sv
// tb_wishbone_host_master
//   Directed bench for wishbone_host_master: host driver tasks, a Wishbone slave
//   with programmable ack latency (0 = never acks), read data = address ^ RD_KEY.
module tb_wishbone_host_master;

   localparam logic [31:0] RD_KEY = 32'h5A5A_5A5A;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [1:0]  in_command = '0;
   logic [31:0] in_address = '0;
   logic [15:0] in_data_count = '0;
   logic [31:0] in_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [7:0]  out_status;
   logic [31:0] out_address;
   logic [31:0] out_data;
   logic        out_last;
   logic        wbm_we_o, wbm_cyc_o, wbm_stb_o;
   logic [3:0]  wbm_sel_o;
   logic [31:0] wbm_adr_o, wbm_dat_o;
   logic        wbm_ack_i = 1'b0;
   logic [31:0] wbm_dat_i = '0;
   logic        wbm_int_i = 1'b0;

   int n_checks = 0;
   int n_pass   = 0;

   int ack_lat = 0;
   int wcnt    = 0;
   logic [31:0] wr_adr[$];
   logic [31:0] wr_dat[$];
   logic [3:0]  wr_sel[$];
   logic [31:0] rd_adr[$];

   logic cyc_seen = 1'b0;
   logic mon_en   = 1'b0;
   int   drops    = 0;

   logic [7:0]  st;
   logic [31:0] ad, dt;
   logic        lst;
   int          sh, cl, mv, n;

   wishbone_host_master #(.TIMEOUT(32'd20)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_command(in_command),
      .in_address(in_address), .in_data_count(in_data_count), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_status(out_status),
      .out_address(out_address), .out_data(out_data), .out_last(out_last),
      .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
      .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
      .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i), .wbm_int_i(wbm_int_i)
   );

   always #5 clk = ~clk;

   // Slave: ack ack_lat cycles after strobe is first seen, one-cycle ack pulse.
   always @(posedge clk) begin
      wbm_ack_i <= 1'b0;
      if (wbm_cyc_o && wbm_stb_o && !wbm_ack_i && ack_lat != 0) begin
         if (wcnt + 1 == ack_lat) begin
            wbm_ack_i <= 1'b1;
            wcnt      <= 0;
            wbm_dat_i <= wbm_adr_o ^ RD_KEY;
            if (wbm_we_o) begin
               wr_adr.push_back(wbm_adr_o);
               wr_dat.push_back(wbm_dat_o);
               wr_sel.push_back(wbm_sel_o);
            end else begin
               rd_adr.push_back(wbm_adr_o);
            end
         end else begin
            wcnt <= wcnt + 1;
         end
      end else begin
         wcnt <= 0;
      end
   end

   always @(negedge clk) begin
      if (wbm_cyc_o) cyc_seen = 1'b1;
      if (mon_en && cyc_seen && !wbm_cyc_o && !out_valid) drops++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
      else n_pass++;
   endtask

   task automatic send_beat(input logic [1:0] cmd, input logic [31:0] addr,
                            input logic [15:0] cnt, input logic [31:0] data);
      int k = 0;
      @(negedge clk);
      in_valid = 1'b1; in_command = cmd; in_address = addr;
      in_data_count = cnt; in_data = data;
      while (!in_ready && k < 300) begin @(negedge clk); k++; end
      if (!in_ready) begin
         check("beat_accept_wait", 32'd0, 32'd1);
         in_valid = 1'b0;
      end else begin
         @(posedge clk); #1;
         in_valid = 1'b0;
      end
   endtask

   task automatic get_resp(input int stall, output logic [7:0] s, output logic [31:0] a,
                           output logic [31:0] d, output logic l,
                           output int stb_hi, output int cyc_lo, output int moved);
      int k = 0;
      s = '0; a = '0; d = '0; l = 1'b0; stb_hi = 0; cyc_lo = 0; moved = 0;
      @(negedge clk);
      while (!out_valid && k < 300) begin @(negedge clk); k++; end
      if (!out_valid) begin
         check("resp_wait", 32'd0, 32'd1);
         return;
      end
      s = out_status; a = out_address; d = out_data; l = out_last;
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         if (wbm_stb_o)  stb_hi++;
         if (!wbm_cyc_o) cyc_lo++;
         if ({out_valid, out_status, out_address, out_data, out_last} !== {1'b1, s, a, d, l})
            moved++;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_bus", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o}, 32'd0);
      check("rst_adr", wbm_adr_o, 32'd0);

      // PING
      cyc_seen = 1'b0;
      send_beat(2'd0, 32'h0000_0000, 16'd1, 32'd0);
      get_resp(0, st, ad, dt, lst, sh, cl, mv);
      check("ping_status", {24'd0, st}, 32'h00);
      check("ping_data", dt, 32'd0);
      check("ping_last", {31'd0, lst}, 32'd1);
      check("ping_no_cyc", {31'd0, cyc_seen}, 32'd0);

      // WRITE burst of 3, slave acks in 2 clocks
      ack_lat = 2; wr_adr.delete(); wr_dat.delete(); wr_sel.delete();
      cyc_seen = 1'b0; drops = 0; mon_en = 1'b1;
      send_beat(2'd1, 32'h0100_0010, 16'd3, 32'hAAAA_0001);
      send_beat(2'd1, 32'h0, 16'd0, 32'hBBBB_0002);
      send_beat(2'd1, 32'h0, 16'd0, 32'hCCCC_0003);
      get_resp(0, st, ad, dt, lst, sh, cl, mv);
      mon_en = 1'b0;
      check("wr_count", wr_adr.size(), 32'd3);
      check("wr_adr0", wr_adr[0], 32'h0100_0010);
      check("wr_adr1", wr_adr[1], 32'h0100_0011);
      check("wr_adr2", wr_adr[2], 32'h0100_0012);
      check("wr_dat0", wr_dat[0], 32'hAAAA_0001);
      check("wr_dat1", wr_dat[1], 32'hBBBB_0002);
      check("wr_dat2", wr_dat[2], 32'hCCCC_0003);
      check("wr_sel", {28'd0, wr_sel[1]}, 32'hF);
      check("wr_cyc_drops", drops, 32'd0);
      check("wr_status", {24'd0, st}, 32'h00);
      check("wr_resp_data", dt, 32'd3);
      check("wr_resp_addr", ad, 32'h0100_0010);
      check("wr_last", {31'd0, lst}, 32'd1);

      // READ of 2 across the 24-bit wrap, first beat stalled 5 clocks
      ack_lat = 2; rd_adr.delete();
      send_beat(2'd2, 32'h00FF_FFFF, 16'd2, 32'd0);
      get_resp(5, st, ad, dt, lst, sh, cl, mv);
      check("rd0_addr", ad, 32'h00FF_FFFF);
      check("rd0_data", dt, 32'h5AA5_A5A5);
      check("rd0_last", {31'd0, lst}, 32'd0);
      check("rd_stall_stb", sh, 32'd0);
      check("rd_stall_cyc", cl, 32'd0);
      check("rd_stall_stable", mv, 32'd0);
      get_resp(0, st, ad, dt, lst, sh, cl, mv);
      check("rd1_addr", ad, 32'h0000_0000);
      check("rd1_data", dt, 32'h5A5A_5A5A);
      check("rd1_last", {31'd0, lst}, 32'd1);
      check("rd_bus_adr1", rd_adr[1], 32'h0000_0000);

      // READ with no ack -> timeout after 20 clocks of strobe
      ack_lat = 0;
      send_beat(2'd2, 32'h0200_0000, 16'd1, 32'd0);
      n = 0;
      while (n < 200) begin
         @(negedge clk);
         if (!wbm_cyc_o) break;
         n++;
      end
      check("tmo_cycles", n, 32'd20);
      get_resp(0, st, ad, dt, lst, sh, cl, mv);
      check("tmo_status", {24'd0, st}, 32'h01);
      check("tmo_data", dt, 32'd0);
      check("tmo_last", {31'd0, lst}, 32'd1);

      // Interrupt edge during a 4-word READ
      ack_lat = 1; rd_adr.delete();
      send_beat(2'd2, 32'h0300_0000, 16'd4, 32'd0);
      @(negedge clk) wbm_int_i = 1'b1;
      get_resp(0, st, ad, dt, lst, sh, cl, mv);
      check("irq_rd0", dt, 32'h595A_5A5A);
      get_resp(0, st, ad, dt, lst, sh, cl, mv);
      check("irq_rd1", dt, 32'h595A_5A5B);
      get_resp(0, st, ad, dt, lst, sh, cl, mv);
      check("irq_rd2", dt, 32'h595A_5A58);
      get_resp(0, st, ad, dt, lst, sh, cl, mv);
      check("irq_rd3", dt, 32'h595A_5A59);
      check("irq_rd3_last", {31'd0, lst}, 32'd1);
      check("irq_no_early_int", rd_adr.size(), 32'd4);
      get_resp(0, st, ad, dt, lst, sh, cl, mv);
      check("int_status", {24'd0, st}, 32'h80);
      check("int_data", dt, 32'hA55A_5A5A);
      check("int_addr", ad, 32'hFF00_0000);
      check("int_bus_adr", rd_adr[4], 32'hFF00_0000);
      wbm_int_i = 1'b0;

      // Count 0 is treated as 1
      ack_lat = 1; wr_adr.delete(); wr_dat.delete(); wr_sel.delete();
      send_beat(2'd1, 32'h0400_0000, 16'd0, 32'hDDDD_0004);
      get_resp(0, st, ad, dt, lst, sh, cl, mv);
      check("cnt0_writes", wr_adr.size(), 32'd1);
      check("cnt0_resp_data", dt, 32'd1);

      // Reserved command
      cyc_seen = 1'b0;
      send_beat(2'd3, 32'h0500_0000, 16'd1, 32'd0);
      get_resp(0, st, ad, dt, lst, sh, cl, mv);
      check("bad_status", {24'd0, st}, 32'h02);
      check("bad_no_cyc", {31'd0, cyc_seen}, 32'd0);

      // Reset while a write strobe is outstanding
      ack_lat = 0;
      send_beat(2'd1, 32'h0600_0000, 16'd2, 32'h1234_5678);
      @(negedge clk);
      check("pre_rst_stb", {31'd0, wbm_stb_o}, 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      check("post_rst_bus", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o}, 32'd0);
      check("post_rst_adr", wbm_adr_o, 32'd0);
      check("post_rst_dat", wbm_dat_o, 32'd0);
      check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk) rst = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
